row_cfg_loader: RTL and testbench
=================================

ROW_CFG_LOADER -- requirements
Module: row_cfg_loader

Interface
REQ-001 Parameter ADDR_W, default 16, config-memory word address width.
REQ-002 Parameter CFG_W, default `PE_inst, width of one configuration word.
REQ-003 Parameter N_TGT, fixed at 5: targets LSU, PE_0, PE_1, PE_2, PE_3.
REQ-004 clk  in  1  single clock; all state changes on its rising edge.
REQ-005 rst  in  1  reset, synchronous and active-low.
REQ-006 start  in  1  one-cycle request to load and run one row configuration; honoured only in IDLE.
REQ-007 halt  in  1  abort request; honoured in any state except IDLE.
REQ-008 cfg_base  in  ADDR_W  address of the first of 5 consecutive config words; sampled with start.
REQ-009 run_len  in  16  number of run cycles; sampled with start.
REQ-010 cfg_rdata  in  CFG_W  config-memory read data.
REQ-011 cfg_rvalid  in  1  cfg_rdata is valid this cycle; arbitrary latency of 1 or more cycles after cfg_rreq.
REQ-012 cfg_rreq  out  1  one-cycle read strobe.
REQ-013 cfg_raddr  out  ADDR_W  read address, valid with cfg_rreq.
REQ-014 PE_config  out  CFG_W  registered config word broadcast to the row.
REQ-015 init_sel  out  5  one-hot target select: bit4 LSU, bit3 PE_0, bit2 PE_1, bit1 PE_2, bit0 PE_3.
REQ-016 init_en  out  1  one-cycle write strobe qualifying init_sel and PE_config.
REQ-017 run  out  1  row execute enable.
REQ-018 busy  out  1  high in every state except IDLE.
REQ-019 done  out  1  one-cycle pulse on normal completion.
REQ-020 aborted  out  1  one-cycle pulse on completion by halt.

Function
REQ-021 States: IDLE, REQ, WAIT, LOAD, RUN, DONE.
REQ-022 IDLE + start: latch cfg_base, run_len, and idx=0, then go to REQ; start in any other state is ignored.
REQ-023 REQ: assert cfg_rreq for one cycle with cfg_raddr=base+idx (mod 2^ADDR_W, wrap permitted), then go to WAIT.
REQ-024 WAIT: hold until cfg_rvalid; cfg_rvalid outside WAIT is ignored.
REQ-025 WAIT + cfg_rvalid: register PE_config=cfg_rdata, set init_sel=1<<(4-idx), assert init_en, and go to LOAD; PE_config, init_sel and init_en all appear in the cycle after the cfg_rvalid cycle.
REQ-026 LOAD (one cycle): deassert init_en and clear init_sel; PE_config holds its value.
REQ-027 LOAD exit: if idx<4, increment idx and go to REQ; if idx==4, go to RUN.
REQ-028 RUN: assert run, count cycles, and leave after exactly run_len cycles of run high.
REQ-029 run_len==0: RUN is skipped, run never asserts, and the FSM goes LOAD->DONE.
REQ-030 DONE (one cycle): pulse done, then go to IDLE.
REQ-031 Exactly one init_en pulse occurs per target per load; init_sel is never multi-hot and is zero whenever init_en is low.
REQ-032 halt, priority over all other events in the same cycle: next cycle run=0, init_en=0, init_sel=0, cfg_rreq=0, aborted=1, state=IDLE; a read already outstanding is discarded.
REQ-033 halt and start asserted together in IDLE: start wins and halt is ignored.
REQ-034 Minimum load latency is start -> first init_en = 3 cycles with a 1-cycle memory.

Reset
REQ-035 rst low at a clock edge: state=IDLE, idx=0, run counter=0, and PE_config, init_sel, init_en, run, cfg_rreq, cfg_raddr, busy, done, aborted all 0.
REQ-036 Reset mid-operation behaves identically to REQ-035; no pulse is emitted on reset exit.

Verification
REQ-037 Normal load: base=0x0100, run_len=3, 1-cycle memory returning 0xA0..0xA4 -> reads at 0x0100..0x0104; init_sel 10000,01000,00100,00010,00001 paired with PE_config A0..A4; then run high for exactly 3 cycles; then done pulses once.
REQ-038 Variable latency: cfg_rvalid delayed 4 cycles per read -> same ordering, one init_en per word, no extra cfg_rreq.
REQ-039 Address wrap: base=0xFFFE -> addresses FFFE, FFFF, 0000, 0001, 0002.
REQ-040 Zero run: run_len=0 -> all 5 loads occur, run stays 0, done pulses.
REQ-041 Halt in RUN at cycle 2 of run_len=10 -> run falls next cycle, aborted pulses, done never asserts, busy=0; halt in WAIT -> the later cfg_rvalid produces no init_en.
REQ-042 Reset in WAIT and spurious start during RUN -> all outputs zero after the rst edge; start during RUN does not alter the count or the addresses.

Source files
------------

// File: rtl/row_cfg_loader.sv
// row_cfg_loader: fetches the five configuration words of one processing row
// (LSU, PE_0..PE_3) from config memory, broadcasts each one with a one-hot
// target strobe, then holds the row in execution for run_len cycles.
//
// Ports
//   clk, rst            clock, synchronous active-low reset
//   start, halt         launch request (IDLE only) / abort request (non-IDLE)
//   cfg_base, run_len   first config word address and run length, taken with start
//   cfg_rreq, cfg_raddr one-cycle memory read strobe and its address
//   cfg_rdata, cfg_rvalid  memory read data and its qualifier (latency >= 1)
//   PE_config           config word broadcast to the row
//   init_sel, init_en   one-hot target (bit4 LSU .. bit0 PE_3) and write strobe
//   run, busy           row execute enable, controller not idle
//   done, aborted       one-cycle completion pulses (normal / by halt)

`ifndef PE_inst
`define PE_inst 32
`endif

module row_cfg_loader #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned CFG_W  = `PE_inst,
  parameter int unsigned N_TGT  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              halt,
  input  logic [ADDR_W-1:0] cfg_base,
  input  logic [15:0]       run_len,
  input  logic [CFG_W-1:0]  cfg_rdata,
  input  logic              cfg_rvalid,
  output logic              cfg_rreq,
  output logic [ADDR_W-1:0] cfg_raddr,
  output logic [CFG_W-1:0]  PE_config,
  output logic [N_TGT-1:0]  init_sel,
  output logic              init_en,
  output logic              run,
  output logic              busy,
  output logic              done,
  output logic              aborted
);

  localparam int unsigned IDX_W = 3;
  localparam int unsigned RUN_W = 16;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_TGT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_LOAD,
    S_RUN,
    S_DONE
  } state_t;

  state_t             state;
  logic [ADDR_W-1:0]  base_q;
  logic [RUN_W-1:0]   run_len_q;
  logic [RUN_W-1:0]   run_cnt;
  logic [IDX_W-1:0]   idx;
  // A read was in flight when halt hit; its response must be swallowed.
  logic               stale;

  logic [IDX_W-1:0]   idx_nxt_c;
  logic [N_TGT-1:0]   sel_c;
  logic               fresh_rvalid_c;

  // Target select walks from the MSB (LSU) down to the LSB (PE_3).
  assign idx_nxt_c      = idx + IDX_W'(1);
  assign sel_c          = {1'b1, {(N_TGT-1){1'b0}}} >> idx;
  assign fresh_rvalid_c = cfg_rvalid && !stale;

  // Controller state and all registered outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= S_IDLE;
      base_q    <= '0;
      run_len_q <= '0;
      run_cnt   <= '0;
      idx       <= '0;
      stale     <= 1'b0;
      cfg_rreq  <= 1'b0;
      cfg_raddr <= '0;
      PE_config <= '0;
      init_sel  <= '0;
      init_en   <= 1'b0;
      run       <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      aborted   <= 1'b0;
    end else begin
      // Pulse outputs default low; init_sel is only non-zero alongside init_en.
      cfg_rreq <= 1'b0;
      init_en  <= 1'b0;
      init_sel <= '0;
      done     <= 1'b0;
      aborted  <= 1'b0;

      if (stale && cfg_rvalid) begin
        stale <= 1'b0;
      end

      if (halt && (state != S_IDLE)) begin
        // Abort wins over every other event in the same cycle.
        state   <= S_IDLE;
        run     <= 1'b0;
        busy    <= 1'b0;
        idx     <= '0;
        run_cnt <= '0;
        aborted <= 1'b1;
        stale   <= (state == S_REQ) || ((state == S_WAIT) && !fresh_rvalid_c);
      end else begin
        case (state)
          S_IDLE: begin
            if (start) begin
              base_q    <= cfg_base;
              run_len_q <= run_len;
              idx       <= '0;
              cfg_rreq  <= 1'b1;
              cfg_raddr <= cfg_base;
              busy      <= 1'b1;
              state     <= S_REQ;
            end
          end

          S_REQ: begin
            state <= S_WAIT;
          end

          S_WAIT: begin
            if (fresh_rvalid_c) begin
              PE_config <= cfg_rdata;
              init_sel  <= sel_c;
              init_en   <= 1'b1;
              state     <= S_LOAD;
            end
          end

          S_LOAD: begin
            if (idx != LAST_IDX) begin
              // Address arithmetic wraps modulo 2^ADDR_W.
              idx       <= idx_nxt_c;
              cfg_rreq  <= 1'b1;
              cfg_raddr <= base_q + ADDR_W'(idx_nxt_c);
              state     <= S_REQ;
            end else if (run_len_q == '0) begin
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              // run_cnt counts run-high cycles, this entry cycle being the first.
              run     <= 1'b1;
              run_cnt <= RUN_W'(1);
              state   <= S_RUN;
            end
          end

          S_RUN: begin
            if (run_cnt == run_len_q) begin
              run     <= 1'b0;
              run_cnt <= '0;
              done    <= 1'b1;
              state   <= S_DONE;
            end else begin
              run_cnt <= run_cnt + RUN_W'(1);
            end
          end

          S_DONE: begin
            busy  <= 1'b0;
            idx   <= '0;
            state <= S_IDLE;
          end

          default: begin
            run   <= 1'b0;
            busy  <= 1'b0;
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_row_cfg_loader.sv
// Directed bench for row_cfg_loader: a table of complete load/run scenarios
// plus hand-written halt, reset and spurious-start sequences.

module tb_row_cfg_loader;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned CFG_W  = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start = 1'b0;
  logic              halt = 1'b0;
  logic [ADDR_W-1:0] cfg_base = '0;
  logic [15:0]       run_len = '0;
  logic [CFG_W-1:0]  cfg_rdata;
  logic              cfg_rvalid;
  logic              cfg_rreq;
  logic [ADDR_W-1:0] cfg_raddr;
  logic [CFG_W-1:0]  PE_config;
  logic [4:0]        init_sel;
  logic              init_en;
  logic              run;
  logic              busy;
  logic              done;
  logic              aborted;

  row_cfg_loader #(.ADDR_W(ADDR_W), .CFG_W(CFG_W), .N_TGT(5)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .halt      (halt),
    .cfg_base  (cfg_base),
    .run_len   (run_len),
    .cfg_rdata (cfg_rdata),
    .cfg_rvalid(cfg_rvalid),
    .cfg_rreq  (cfg_rreq),
    .cfg_raddr (cfg_raddr),
    .PE_config (PE_config),
    .init_sel  (init_sel),
    .init_en   (init_en),
    .run       (run),
    .busy      (busy),
    .done      (done),
    .aborted   (aborted)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Scenario table: inputs and hand-computed expectations.
  typedef struct {
    logic [15:0] base;
    logic [15:0] len;
    int          lat;
    logic [15:0] addr [5];
    int          first_en;   // cycles from start to first init_en
  } vec_t;

  vec_t tbl [5];
  logic [4:0] exp_sel [5];

  // Memory model: fixed latency, data = 0xA0 + (addr - current base).
  int          mem_lat  = 1;
  logic [15:0] cur_base = '0;
  logic [15:0] mem_addr;

  initial begin
    cfg_rvalid = 1'b0;
    cfg_rdata  = 32'hDEAD_BEEF;
    forever begin
      @(negedge clk);
      if (cfg_rreq === 1'b1) begin
        mem_addr = cfg_raddr;
        repeat (mem_lat) @(posedge clk);
        #1;
        cfg_rvalid = 1'b1;
        cfg_rdata  = 32'hA0 + 32'(16'(mem_addr - cur_base));
        @(posedge clk);
        #1;
        cfg_rvalid = 1'b0;
        cfg_rdata  = 32'hDEAD_BEEF;
      end
    end
  end

  // Output monitor, sampled mid-cycle.
  logic [15:0] log_addr [$];
  logic [4:0]  log_sel  [$];
  logic [31:0] log_data [$];
  int run_cyc, done_cnt, abort_cnt, inv_err, first_en_cyc, start_cyc;

  task automatic clear_logs();
    log_addr.delete();
    log_sel.delete();
    log_data.delete();
    run_cyc = 0; done_cnt = 0; abort_cnt = 0; inv_err = 0; first_en_cyc = -1;
  endtask

  initial begin
    clear_logs();
    forever begin
      @(negedge clk);
      if (rst) begin
        if (cfg_rreq) log_addr.push_back(cfg_raddr);
        if (init_en) begin
          if (log_sel.size() == 0) first_en_cyc = cyc;
          log_sel.push_back(init_sel);
          log_data.push_back(PE_config);
          if (!$onehot(init_sel)) inv_err++;
        end else if (init_sel != 5'b0) begin
          inv_err++;
        end
        if (run) run_cyc++;
        if (done) done_cnt++;
        if (aborted) abort_cnt++;
        if (done && aborted) inv_err++;
      end
    end
  end

  task automatic do_start(input logic [15:0] b, input logic [15:0] len);
    @(negedge clk);
    start = 1'b1; cfg_base = b; run_len = len; start_cyc = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_end(input int bound, output bit got);
    got = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (done || aborted) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_run(input int bound, output bit got);
    got = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (run) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  task automatic run_scenario(input int i);
    bit got;
    clear_logs();
    mem_lat  = tbl[i].lat;
    cur_base = tbl[i].base;
    do_start(tbl[i].base, tbl[i].len);
    wait_end(400, got);
    chk($sformatf("v%0d_end_reached", i), got, 1'b1);
    @(negedge clk);
    chk($sformatf("v%0d_busy_idle", i), busy, 1'b0);
    chk($sformatf("v%0d_n_reads", i), log_addr.size(), 5);
    for (int k = 0; k < 5; k++) begin
      if (k < log_addr.size())
        chk($sformatf("v%0d_addr%0d", i, k), log_addr[k], tbl[i].addr[k]);
    end
    chk($sformatf("v%0d_n_init_en", i), log_sel.size(), 5);
    for (int k = 0; k < 5; k++) begin
      if (k < log_sel.size()) begin
        chk($sformatf("v%0d_sel%0d", i, k), log_sel[k], exp_sel[k]);
        chk($sformatf("v%0d_cfg%0d", i, k), log_data[k], 32'hA0 + 32'(k));
      end
    end
    chk($sformatf("v%0d_first_en_latency", i), first_en_cyc - start_cyc, tbl[i].first_en);
    chk($sformatf("v%0d_run_cycles", i), run_cyc, tbl[i].len);
    chk($sformatf("v%0d_done_pulses", i), done_cnt, 1);
    chk($sformatf("v%0d_abort_pulses", i), abort_cnt, 0);
    chk($sformatf("v%0d_invariants", i), inv_err, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit got;

    exp_sel = '{5'b10000, 5'b01000, 5'b00100, 5'b00010, 5'b00001};
    tbl[0].base = 16'h0100; tbl[0].len = 16'd3; tbl[0].lat = 1; tbl[0].first_en = 3;
    tbl[0].addr = '{16'h0100, 16'h0101, 16'h0102, 16'h0103, 16'h0104};
    tbl[1].base = 16'h0200; tbl[1].len = 16'd5; tbl[1].lat = 4; tbl[1].first_en = 6;
    tbl[1].addr = '{16'h0200, 16'h0201, 16'h0202, 16'h0203, 16'h0204};
    tbl[2].base = 16'hFFFE; tbl[2].len = 16'd2; tbl[2].lat = 2; tbl[2].first_en = 4;
    tbl[2].addr = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001, 16'h0002};
    tbl[3].base = 16'h0300; tbl[3].len = 16'd0; tbl[3].lat = 1; tbl[3].first_en = 3;
    tbl[3].addr = '{16'h0300, 16'h0301, 16'h0302, 16'h0303, 16'h0304};
    tbl[4].base = 16'h0000; tbl[4].len = 16'd1; tbl[4].lat = 3; tbl[4].first_en = 5;
    tbl[4].addr = '{16'h0000, 16'h0001, 16'h0002, 16'h0003, 16'h0004};

    // Reset state.
    repeat (3) @(negedge clk);
    chk("rst_outputs_zero",
        {PE_config, init_sel, init_en, run, cfg_rreq, cfg_raddr, busy, done, aborted}, '0);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_exit_busy", busy, 1'b0);
    chk("rst_exit_pulses", {done, aborted}, 2'b00);

    // Table-driven full loads.
    for (int i = 0; i < 5; i++) run_scenario(i);

    // Halt during RUN, in the second run cycle of run_len=10.
    clear_logs();
    mem_lat = 1; cur_base = 16'h0500;
    do_start(16'h0500, 16'd10);
    wait_run(100, got);
    chk("hrun_run_seen", got, 1'b1);
    @(negedge clk);
    halt = 1'b1;
    @(negedge clk);
    halt = 1'b0;
    chk("hrun_run_low", run, 1'b0);
    chk("hrun_aborted", aborted, 1'b1);
    chk("hrun_busy_low", busy, 1'b0);
    chk("hrun_strobes_low", {init_en, init_sel, cfg_rreq}, '0);
    @(negedge clk);
    chk("hrun_abort_one_cycle", aborted, 1'b0);
    repeat (3) @(negedge clk);
    chk("hrun_run_cycles", run_cyc, 2);
    chk("hrun_no_done", done_cnt, 0);
    chk("hrun_abort_count", abort_cnt, 1);

    // Halt during WAIT: the late response must not load anything.
    clear_logs();
    mem_lat = 4; cur_base = 16'h0600;
    do_start(16'h0600, 16'd2);
    chk("hwait_rreq", cfg_rreq, 1'b1);
    @(negedge clk);
    halt = 1'b1;
    @(negedge clk);
    halt = 1'b0;
    chk("hwait_aborted", aborted, 1'b1);
    chk("hwait_busy_low", busy, 1'b0);
    repeat (8) @(negedge clk);
    chk("hwait_no_init_en", log_sel.size(), 0);
    chk("hwait_no_done", done_cnt, 0);
    chk("hwait_one_read", log_addr.size(), 1);
    run_scenario(0);

    // start and halt together in IDLE: start wins.
    clear_logs();
    mem_lat = 1; cur_base = 16'h0100;
    @(negedge clk);
    start = 1'b1; halt = 1'b1; cfg_base = 16'h0100; run_len = 16'd3;
    @(negedge clk);
    start = 1'b0; halt = 1'b0;
    chk("sh_busy", busy, 1'b1);
    chk("sh_no_abort", aborted, 1'b0);
    wait_end(200, got);
    chk("sh_end_reached", got, 1'b1);
    @(negedge clk);
    chk("sh_done", done_cnt, 1);
    chk("sh_loads", log_sel.size(), 5);

    // Reset while waiting for read data.
    clear_logs();
    mem_lat = 4; cur_base = 16'h0700;
    do_start(16'h0700, 16'd4);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rwait_outputs_zero",
        {PE_config, init_sel, init_en, run, cfg_rreq, cfg_raddr, busy, done, aborted}, '0);
    rst = 1'b1;
    repeat (8) @(negedge clk);
    chk("rwait_no_init_en", log_sel.size(), 0);
    chk("rwait_no_pulses", done_cnt + abort_cnt, 0);
    chk("rwait_idle", busy, 1'b0);

    // Spurious start during RUN must not disturb the run or issue reads.
    clear_logs();
    mem_lat = 1; cur_base = 16'h0400;
    do_start(16'h0400, 16'd6);
    wait_run(100, got);
    chk("sp_run_seen", got, 1'b1);
    start = 1'b1; cfg_base = 16'h0900; run_len = 16'd2;
    @(negedge clk);
    start = 1'b0;
    wait_end(200, got);
    chk("sp_end_reached", got, 1'b1);
    @(negedge clk);
    chk("sp_run_cycles", run_cyc, 6);
    chk("sp_n_reads", log_addr.size(), 5);
    if (log_addr.size() == 5) chk("sp_last_addr", log_addr[4], 16'h0404);
    chk("sp_done", done_cnt, 1);
    chk("sp_invariants", inv_err, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
